// File: rtl/rv32i_mmio_pkg.sv
// rv32i_mmio_pkg: shared address map, timer control bit positions and decode helper
package rv32i_mmio_pkg;

    localparam logic [31:0] ADDR_LED  = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_TCNT = 32'hFFFF_0010;
    localparam logic [31:0] ADDR_TCMP = 32'hFFFF_0014;
    localparam logic [31:0] ADDR_TCTL = 32'hFFFF_0018;

    localparam int TCTL_EN     = 0;
    localparam int TCTL_IRQ_EN = 1;
    localparam int TCTL_MATCH  = 2;
    localparam int TCTL_AUTO   = 3;

    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TCNT,
        SEL_TCMP,
        SEL_TCTL
    } sel_t;

    // Word-granular decode: the byte offset bits never influence the target.
    function automatic sel_t decode(input logic [31:0] addr, input int unsigned ram_words);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        return ({2'b00, addr[31:2]} < ram_words) ? SEL_RAM  :
               (a == ADDR_LED)                   ? SEL_LED  :
               (a == ADDR_SW)                    ? SEL_SW   :
               (a == ADDR_TCNT)                  ? SEL_TCNT :
               (a == ADDR_TCMP)                  ? SEL_TCMP :
               (a == ADDR_TCTL)                  ? SEL_TCTL : SEL_NONE;
    endfunction

endpackage

// File: rtl/rv32i_mmio_timer.sv
// rv32i_mmio_timer: free-running compare timer with sticky match flag and optional auto-reload
module rv32i_mmio_timer
    import rv32i_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tcnt_we,
    input  logic        tcmp_we,
    input  logic        tctl_we,
    input  logic [31:0] wdata,
    output logic [31:0] tcnt,
    output logic [31:0] tcmp,
    output logic [31:0] tctl,
    output logic        irq
);

    logic en;
    logic irq_en;
    logic match;
    logic auto_reload;
    logic hit;

    assign hit = en && (tcnt == tcmp);
    assign irq = match & irq_en;

    // Counter, compare and control registers; a CPU write to TCNT beats count/reload, a match set beats W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt        <= '0;
            tcmp        <= TCMP_RESET;
            en          <= 1'b0;
            irq_en      <= 1'b0;
            match       <= 1'b0;
            auto_reload <= 1'b0;
        end else begin
            tcnt  <= tcnt_we ? wdata : (hit && auto_reload) ? '0 : en ? tcnt + 32'd1 : tcnt;
            match <= hit | (match & ~(tctl_we & wdata[TCTL_MATCH]));
            if (tcmp_we) tcmp <= wdata;
            if (tctl_we) begin
                en          <= wdata[TCTL_EN];
                irq_en      <= wdata[TCTL_IRQ_EN];
                auto_reload <= wdata[TCTL_AUTO];
            end
        end
    end

    // Assemble the control/status read view; unused bits read as zero.
    always_comb begin
        tctl              = '0;
        tctl[TCTL_EN]     = en;
        tctl[TCTL_IRQ_EN] = irq_en;
        tctl[TCTL_MATCH]  = match;
        tctl[TCTL_AUTO]   = auto_reload;
    end

endmodule

// File: rtl/rv32i_data_bus_responder.sv
// rv32i_data_bus_responder: single-cycle data bus slave with RAM, LEDs, switches and a timer
module rv32i_data_bus_responder
    import rv32i_mmio_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Memwrite,
    input  logic [31:0] Memaddr,
    input  logic [31:0] MemWdata,
    output logic [31:0] MemRdata,
    output logic [7:0]  leds,
    input  logic [7:0]  switches,
    output logic        timer_irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] idx;
    logic [7:0]    sw_meta;
    logic [7:0]    sw_sync;
    logic [31:0]   tcnt;
    logic [31:0]   tcmp;
    logic [31:0]   tctl;
    logic          we;
    sel_t          sel;

    assign sel = decode(Memaddr, RAM_WORDS);
    assign idx = Memaddr[AW+1:2];
    assign we  = Memwrite & ~reset;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && sel == SEL_RAM) ram[idx] <= MemWdata;
    end

    // LED register and two-stage switch synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds    <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (we && sel == SEL_LED) leds <= MemWdata[7:0];
        end
    end

    rv32i_mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .tcnt_we (we && sel == SEL_TCNT),
        .tcmp_we (we && sel == SEL_TCMP),
        .tctl_we (we && sel == SEL_TCTL),
        .wdata   (MemWdata),
        .tcnt    (tcnt),
        .tcmp    (tcmp),
        .tctl    (tctl),
        .irq     (timer_irq)
    );

    // Zero-latency read mux; unmapped addresses read as zero.
    always_comb begin
        MemRdata = (sel == SEL_RAM)  ? ram[idx]         :
                   (sel == SEL_LED)  ? {24'h0, leds}    :
                   (sel == SEL_SW)   ? {24'h0, sw_sync} :
                   (sel == SEL_TCNT) ? tcnt             :
                   (sel == SEL_TCMP) ? tcmp             :
                   (sel == SEL_TCTL) ? tctl             : 32'h0;
    end

endmodule

// File: doc/rv32i_data_bus_responder.md
RV32I_DATA_BUS_RESPONDER -- requirements
Module: rv32i_data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256; number of 32-bit data RAM words (power of 2, 16..1024).
REQ-002 SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-004 SHALL have port Memwrite, input, 1 bit; CPU store strobe for the current cycle.
REQ-005 SHALL have port Memaddr, input, 32 bits; CPU byte address.
REQ-006 SHALL have port MemWdata, input, 32 bits; store data.
REQ-007 SHALL have port MemRdata, output, 32 bits; load data, combinational from Memaddr and current state.
REQ-008 SHALL have port leds, output, 8 bits; LED register value.
REQ-009 SHALL have port switches, input, 8 bits; asynchronous external inputs.
REQ-010 SHALL have port timer_irq, output, 1 bit; timer interrupt request.

Function
REQ-011 SHALL decode the address map as follows: RAM at 0x0000_0000 to 4*RAM_WORDS-1; LED at 0xFFFF_0000; SW at 0xFFFF_0004; TCNT at 0xFFFF_0010; TCMP at 0xFFFF_0014; TCTL at 0xFFFF_0018.
REQ-012 SHALL support word accesses only; Memaddr[1:0] is ignored.
REQ-013 SHALL return 0 on MemRdata for a read of any unmapped address, and SHALL ignore writes to unmapped addresses and to SW.
REQ-014 SHALL present read data in the same cycle as the address, with no added latency, matching single-cycle CPU timing.
REQ-015 SHALL commit a write at the rising clk edge when Memwrite=1; a read of the same address in that cycle returns the old value.
REQ-016 SHALL return {24'b0, leds} for an LED read; writes load MemWdata[7:0].
REQ-017 SHALL pass switches through a 2-flop synchronizer; a SW read returns {24'b0, sync}, with 2-cycle input-to-visibility latency.
REQ-018 SHALL define TCTL bits as: bit0 EN, bit1 IRQ_EN, bit2 MATCH (sticky), bit3 AUTO_RELOAD; other bits read 0.
REQ-019 SHALL increment TCNT by 1 each cycle while EN=1, wrapping 0xFFFF_FFFF to 0.
REQ-020 SHALL set MATCH on the next edge when EN=1 and TCNT==TCMP; if AUTO_RELOAD=1, TCNT SHALL load 0 on that edge instead of incrementing.
REQ-021 SHALL treat a write to TCNT as higher priority than increment and reload in the same cycle.
REQ-022 SHALL update EN, IRQ_EN and AUTO_RELOAD on a TCTL write; writing 1 to bit2 clears MATCH, and writing 0 to bit2 leaves it unchanged.
REQ-023 SHALL give a set priority over a clear when a MATCH set and a W1C occur in the same cycle.
REQ-024 SHALL drive timer_irq = MATCH & IRQ_EN, combinational from registers.
REQ-025 SHALL leave TCNT and MATCH unchanged while EN=0.

Reset
REQ-026 SHALL clear the following on a clk edge with reset=1: leds=0, synchronizer=0, TCNT=0, TCMP=0xFFFF_FFFF, TCTL=0, MATCH=0, so timer_irq=0.
REQ-027 SHALL leave RAM contents unchanged by reset.
REQ-028 SHALL ignore writes in any cycle where reset=1.
REQ-029 SHALL take effect mid-count on the next edge, with the timer resuming only after EN is rewritten.

Structure
REQ-030 SHALL place the address constants, TCTL bit positions and the TCMP reset value in a shared package, rv32i_mmio_pkg.
REQ-031 SHALL implement the timer (TCNT, TCMP, TCTL, compare and reload logic) as the sub-module rv32i_mmio_timer; address decode, RAM, LED and the synchronizer stay at top level.

Verification
REQ-032 SHALL cover the RAM scenario: write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 -> 0xDEAD_BEEF; reading 0x0000_0013 gives the same value.
REQ-033 SHALL cover the unmapped scenario: write 0x1234 to 0x8000_0000, then read it -> 0; RAM word 0 is unchanged.
REQ-034 SHALL cover the timer auto-reload scenario: TCMP=5, TCTL=0xB -> TCNT counts 0..5, then 0; MATCH=1 and timer_irq=1 after the edge where TCNT==5.
REQ-035 SHALL cover the W1C scenario: write TCTL=0xF in the same cycle a match occurs -> MATCH stays 1; a next write of 0xF with no match -> MATCH=0 and timer_irq=0.
REQ-036 SHALL cover the switches scenario: switches=0xA5 -> SW reads 0 for 2 edges, then 0x0000_00A5.
REQ-037 SHALL cover the reset mid-operation scenario: reset asserted while TCNT=100 and leds=0x3C -> after the edge, TCNT=0, leds=0, TCMP=0xFFFF_FFFF, and RAM data is preserved.
